// File: rtl/softproc_onchip_mem_arbiter_pkg.sv
// softproc_onchip_mem_arbiter_pkg: shared owner states, read latency and hold-counter sizing
package softproc_memarb_pkg;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_e;

    localparam int READ_LATENCY = 1;

    function automatic int hold_w(input int max_hold);
        return $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/softproc_onchip_mem_arbiter_if.sv
// softproc_onchip_mem_arbiter_if: one pipelined Avalon-MM slave port with waitrequest/readdatavalid
interface softproc_onchip_mem_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    logic [AW-1:0]   address;
    logic [DW/8-1:0] byteenable;
    logic            read;
    logic            write;
    logic [DW-1:0]   writedata;
    logic            waitrequest;
    logic [DW-1:0]   readdata;
    logic            readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/softproc_onchip_mem_arbiter_rr_pick.sv
// softproc_memarb_rr_pick: combinational round-robin grant with bounded hold
module softproc_memarb_rr_pick
    import softproc_memarb_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int HW       = hold_w(MAX_HOLD)
) (
    input  owner_e          state,
    input  logic [HW-1:0]   hold_cnt,
    input  logic            req0,
    input  logic            req1,
    output logic [1:0]      grant
);
    localparam logic [HW-1:0] MAX_H = HW'(MAX_HOLD);

    logic keep;

    assign keep     = hold_cnt < MAX_H;
    // Under contention the current owner keeps the RAM until its hold budget runs out
    assign grant[0] = req0 & (~req1 | state == IDLE | (state == OWN0 ? keep : ~keep));
    assign grant[1] = req1 & ~grant[0];
endmodule

// File: rtl/softproc_onchip_mem_arbiter.sv
// softproc_onchip_mem_arbiter: shares a single-port RAM between two Avalon-MM requesters.
// Optional perf counters under SOFTPROC_MEMARB_PERF_EN.
module softproc_onchip_mem_arbiter
    import softproc_memarb_pkg::*;
#(
    parameter int AW       = 12,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    softproc_onchip_mem_arbiter_if.slave s0,
    softproc_onchip_mem_arbiter_if.slave s1,
    output logic [AW-1:0]        mem_address,
    output logic [DW/8-1:0]      mem_byteenable,
    output logic                 mem_chipselect,
    output logic                 mem_write,
    output logic [DW-1:0]        mem_writedata,
    output logic                 mem_clken,
    input  logic [DW-1:0]        mem_readdata
`ifdef SOFTPROC_MEMARB_PERF_EN
    ,
    input  logic                 perf_clear,
    output logic [31:0]          perf_grant0,
    output logic [31:0]          perf_grant1,
    output logic [31:0]          perf_conflict
`endif
);
    localparam int HW = hold_w(MAX_HOLD);
    localparam logic [HW-1:0] MAX_H = HW'(MAX_HOLD);

    owner_e        state;
    owner_e        nxt;
    logic [HW-1:0] hold_cnt;
    logic [1:0]    pick;
    logic [1:0]    grant;
    logic          req0;
    logic          req1;
    logic          sel1;
    logic          sel_wr;
    logic          rd_pend;
    logic          rd_own;

    assign req0 = s0.read | s0.write;
    assign req1 = s1.read | s1.write;

    softproc_memarb_rr_pick #(.MAX_HOLD(MAX_HOLD), .HW(HW)) u_pick (
        .state    (state),
        .hold_cnt (hold_cnt),
        .req0     (req0),
        .req1     (req1),
        .grant    (pick)
    );

    // Nothing reaches the RAM while reset is held
    assign grant  = reset ? 2'b00 : pick;
    assign sel1   = grant[1];
    assign nxt    = sel1 ? OWN1 : OWN0;
    assign sel_wr = sel1 ? s1.write : s0.write;

    assign mem_address    = sel1 ? s1.address : s0.address;
    assign mem_writedata  = sel1 ? s1.writedata : s0.writedata;
    assign mem_byteenable = sel_wr ? (sel1 ? s1.byteenable : s0.byteenable) : '1;
    assign mem_chipselect = |grant;
    assign mem_write      = mem_chipselect & sel_wr;
    assign mem_clken      = 1'b1;

    assign s0.waitrequest   = reset | (req0 & ~grant[0]);
    assign s1.waitrequest   = reset | (req1 & ~grant[1]);
    assign s0.readdata      = mem_readdata;
    assign s1.readdata      = mem_readdata;
    assign s0.readdatavalid = ~reset & rd_pend & ~rd_own;
    assign s1.readdatavalid = ~reset & rd_pend & rd_own;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
            rd_pend  <= 1'b0;
            rd_own   <= 1'b0;
        end else begin
            state    <= mem_chipselect ? nxt : IDLE;
            hold_cnt <= !mem_chipselect ? '0 :
                        nxt != state ? HW'(1) :
                        hold_cnt == MAX_H ? hold_cnt : hold_cnt + 1'b1;
            rd_pend  <= mem_chipselect & ~mem_write;
            rd_own   <= sel1;
        end
    end

`ifdef SOFTPROC_MEMARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset | perf_clear) begin
            perf_grant0   <= '0;
            perf_grant1   <= '0;
            perf_conflict <= '0;
        end else begin
            perf_grant0   <= perf_grant0 + {31'b0, grant[0]};
            perf_grant1   <= perf_grant1 + {31'b0, grant[1]};
            perf_conflict <= perf_conflict + {31'b0, req0 & req1};
        end
    end
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(s0.read && s0.write)) else $warning("s0 read and write together, write takes priority");
            assert (!(s1.read && s1.write)) else $warning("s1 read and write together, write takes priority");
        end
    end
`endif
endmodule
